// File: rtl/bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_motion_ctrl
// Description : Vertical-motion and game-phase controller for the bird.
//               Treats the debouncer's single-cycle FLAP pulse as a flap
//               request and the per-frame TICK as the motion update strobe.
//               Integrates gravity and flap impulses into a signed velocity
//               and an unsigned screen Y, and tracks the game phase
//               (IDLE, PLAY, DYING, OVER).
// Ports       : CLK        - system clock
//               RESET      - asynchronous, active-high reset
//               FLAP       - one-cycle flap request
//               TICK       - one-cycle frame tick
//               HIT        - pipe-collision level
//               BIRD_Y     - registered bird Y (pixels, 0 = top)
//               BIRD_VEL   - registered signed velocity (negative = up)
//               PLAYING    - high in PLAY and DYING
//               GAME_OVER  - high in OVER
//               FLAP_CNT   - flaps applied this game, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl #(
  parameter int Y_W      = 10,
  parameter int V_W      = 6,
  parameter int Y_INIT   = 240,
  parameter int CEIL_Y   = 0,
  parameter int FLOOR_Y  = 440,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int MAX_FALL = 10
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           FLAP,
  input  logic           TICK,
  input  logic           HIT,
  output logic [Y_W-1:0] BIRD_Y,
  output logic [V_W-1:0] BIRD_VEL,
  output logic           PLAYING,
  output logic           GAME_OVER,
  output logic [7:0]     FLAP_CNT
);

  // Position arithmetic is done two bits wider and signed so that a flap
  // near the top or a fall near the bottom cannot wrap before clamping.
  localparam int c_ys_w = Y_W + 2;
  // Velocity arithmetic gets one guard bit so VEL+GRAVITY cannot wrap
  // before it is compared against the terminal velocity.
  localparam int c_vx_w = V_W + 1;

  localparam logic [Y_W-1:0]           c_y_init   = Y_W'(Y_INIT);
  localparam logic [Y_W-1:0]           c_ceil_y   = Y_W'(CEIL_Y);
  localparam logic [Y_W-1:0]           c_floor_y  = Y_W'(FLOOR_Y);
  localparam logic signed [c_ys_w-1:0] c_ceil_s   = c_ys_w'(CEIL_Y);
  localparam logic signed [c_ys_w-1:0] c_floor_s  = c_ys_w'(FLOOR_Y);
  localparam logic signed [c_vx_w-1:0] c_grav_x   = c_vx_w'(GRAVITY);
  localparam logic signed [c_vx_w-1:0] c_max_x    = c_vx_w'(MAX_FALL);
  localparam logic [V_W-1:0]           c_max_fall = V_W'(MAX_FALL);
  localparam logic [V_W-1:0]           c_flap_up  = V_W'(-FLAP_VEL);
  localparam logic [7:0]               c_cnt_max  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t         r_state;
  logic [Y_W-1:0] r_y;
  logic [V_W-1:0] r_vel;
  logic [7:0]     r_cnt;
  logic           r_pend;
  logic           r_playing;
  logic           r_game_over;

  logic                     w_flap_apply;
  logic                     w_motion;
  logic signed [c_vx_w-1:0] w_vel_ext;
  logic signed [c_vx_w-1:0] w_vel_inc;
  logic [V_W-1:0]           w_vel_grav;
  logic [V_W-1:0]           w_vel_new;
  logic signed [c_ys_w-1:0] w_y_sum;
  logic                     w_ceil_hit;
  logic                     w_land;

  // Next-motion datapath. Only consumed by the register block when
  // w_motion is high.
  always_comb begin
    // A FLAP arriving together with the TICK counts as pending, so the
    // flap takes effect in that same tick.
    w_flap_apply = (r_state == S_PLAY) && (r_pend || FLAP);

    // HIT wins over TICK in PLAY: the cycle that enters DYING has no motion.
    w_motion = TICK && (((r_state == S_PLAY) && !HIT) || (r_state == S_DYING));

    w_vel_ext = $signed({r_vel[V_W-1], r_vel});
    w_vel_inc = w_vel_ext + c_grav_x;
    if (w_vel_inc > c_max_x) begin
      w_vel_grav = c_max_fall;
    end else begin
      w_vel_grav = w_vel_inc[V_W-1:0];
    end

    w_vel_new = w_flap_apply ? c_flap_up : w_vel_grav;

    w_y_sum = $signed({2'b00, r_y})
            + $signed({{(c_ys_w - V_W){w_vel_new[V_W-1]}}, w_vel_new});

    w_ceil_hit = (w_y_sum <= c_ceil_s);
    w_land     = (w_y_sum >= c_floor_s);
  end

  // Game-phase FSM with motion registers and registered phase outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_y         <= c_y_init;
      r_vel       <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_y   <= c_y_init;
          r_vel <= '0;
          if (FLAP) begin
            // This flap is the starting flap; the first TICK applies it.
            r_state   <= S_PLAY;
            r_pend    <= 1'b1;
            r_playing <= 1'b1;
          end
        end

        S_PLAY: begin
          if (HIT) begin
            r_state <= S_DYING;
            r_vel   <= '0;
            r_pend  <= 1'b0;
          end else if (FLAP && !TICK) begin
            // Repeated flaps between ticks merge into one pending flap.
            r_pend <= 1'b1;
          end
        end

        S_DYING: begin
          // FLAP is ignored; only gravity acts (handled by the motion write).
          r_pend <= 1'b0;
        end

        S_OVER: begin
          if (FLAP) begin
            r_state     <= S_IDLE;
            r_y         <= c_y_init;
            r_vel       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_game_over <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Motion write. Placed after the case so that landing overrides the
      // state assignment above and takes effect in the same update.
      if (w_motion) begin
        if (w_flap_apply) begin
          r_pend <= 1'b0;
          if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        if (w_ceil_hit) begin
          r_y   <= c_ceil_y;
          r_vel <= '0;
        end else if (w_land) begin
          r_y         <= c_floor_y;
          r_vel       <= '0;
          r_state     <= S_OVER;
          r_playing   <= 1'b0;
          r_game_over <= 1'b1;
        end else begin
          r_y   <= w_y_sum[Y_W-1:0];
          r_vel <= w_vel_new;
        end
      end
    end
  end

  assign BIRD_Y    = r_y;
  assign BIRD_VEL  = r_vel;
  assign PLAYING   = r_playing;
  assign GAME_OVER = r_game_over;
  assign FLAP_CNT  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_motion_ctrl
// Description : Self-checking bench for bird_motion_ctrl. A table of
//               single-cycle vectors covers idle, start, flap merging and
//               collision; hand-written sequences cover landing, restart,
//               free fall, ceiling clamp, counter saturation and an
//               asynchronous reset in mid-game.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_motion_ctrl;

  localparam int Y_W = 10;
  localparam int V_W = 6;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           FLAP;
  logic           TICK;
  logic           HIT;
  logic [Y_W-1:0] BIRD_Y;
  logic [V_W-1:0] BIRD_VEL;
  logic           PLAYING;
  logic           GAME_OVER;
  logic [7:0]     FLAP_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bird_motion_ctrl #(
    .Y_W      (Y_W),
    .V_W      (V_W),
    .Y_INIT   (240),
    .CEIL_Y   (0),
    .FLOOR_Y  (440),
    .GRAVITY  (1),
    .FLAP_VEL (8),
    .MAX_FALL (10)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLAP      (FLAP),
    .TICK      (TICK),
    .HIT       (HIT),
    .BIRD_Y    (BIRD_Y),
    .BIRD_VEL  (BIRD_VEL),
    .PLAYING   (PLAYING),
    .GAME_OVER (GAME_OVER),
    .FLAP_CNT  (FLAP_CNT)
  );

  typedef struct {
    logic f;
    logic t;
    logic h;
    int   ey;
    int   ev;
    int   epl;
    int   eov;
    int   ecnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ey, input int ev,
                         input int epl, input int eov, input int ecnt);
    chk({tag, " BIRD_Y"},    int'(BIRD_Y), ey);
    chk({tag, " BIRD_VEL"},  int'($signed(BIRD_VEL)), ev);
    chk({tag, " PLAYING"},   int'(PLAYING), epl);
    chk({tag, " GAME_OVER"}, int'(GAME_OVER), eov);
    chk({tag, " FLAP_CNT"},  int'(FLAP_CNT), ecnt);
  endtask

  // Drive one cycle of inputs, sample 1 ns after the rising edge.
  task automatic step(input logic f, input logic t, input logic h);
    FLAP = f;
    TICK = t;
    HIT  = h;
    @(posedge CLK);
    #1;
    FLAP = 1'b0;
    TICK = 1'b0;
    HIT  = 1'b0;
  endtask

  // Gravity-only ticks from (y0, v0) until landing, checked against a
  // small kinematic model: v = min(v+1, 10); y += v; clamp at 440.
  task automatic fall_to_floor(input string tag, input int y0, input int v0,
                               input int cnt);
    int   m_y;
    int   m_v;
    logic landed;
    m_y    = y0;
    m_v    = v0;
    landed = 1'b0;
    for (int i = 0; i < 100 && !landed; i++) begin
      step(1'b0, 1'b1, 1'b0);
      m_v = (m_v + 1 > 10) ? 10 : m_v + 1;
      m_y = m_y + m_v;
      if (m_y >= 440) begin
        m_y    = 440;
        m_v    = 0;
        landed = 1'b1;
      end
      chk_all($sformatf("%s tick%0d", tag, i), m_y, m_v,
              landed ? 0 : 1, landed ? 1 : 0, cnt);
    end
    chk({tag, " landed GAME_OVER"}, int'(GAME_OVER), 1);
  endtask

  initial begin
    int m_y;
    int m_v;

    //           f     t     h     y    vel pl ov cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 240,  0, 0, 0, 0};  // idle
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 240,  0, 0, 0, 0};  // tick in idle
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 240,  0, 1, 0, 0};  // starting flap
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 232, -8, 1, 0, 1};  // flap applied
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 225, -7, 1, 0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 225, -7, 1, 0, 1};  // pending only
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 225, -7, 1, 0, 1};  // merged
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 217, -8, 1, 0, 2};  // one flap counted
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 209, -8, 1, 0, 3};  // coincident flap
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 202, -7, 1, 0, 3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 196, -6, 1, 0, 3};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 191, -5, 1, 0, 3};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 191,  0, 1, 0, 3};  // HIT beats TICK
    tbl[13] = '{1'b1, 1'b0, 1'b0, 191,  0, 1, 0, 3};  // flap ignored dying
    tbl[14] = '{1'b0, 1'b1, 1'b0, 192,  1, 1, 0, 3};  // gravity only
    tbl[15] = '{1'b1, 1'b1, 1'b0, 194,  2, 1, 0, 3};  // flap+tick ignored
    tbl[16] = '{1'b0, 1'b1, 1'b0, 197,  3, 1, 0, 3};

    RESET = 1'b1;
    FLAP  = 1'b0;
    TICK  = 1'b0;
    HIT   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 240, 0, 0, 0, 0);
    RESET = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].f, tbl[i].t, tbl[i].h);
      chk_all($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ev,
              tbl[i].epl, tbl[i].eov, tbl[i].ecnt);
    end

    // Dying bird falls to the floor.
    fall_to_floor("dying", 197, 3, 3);

    // OVER: frozen, then restart.
    step(1'b0, 1'b1, 1'b0);
    chk_all("over tick", 440, 0, 0, 1, 3);
    step(1'b1, 1'b0, 1'b0);
    chk_all("restart", 240, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("idle tick", 240, 0, 0, 0, 0);

    // Free fall from a fresh start with no further flaps.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("ff start", 232, -8, 1, 0, 1);
    fall_to_floor("freefall", 232, -8, 1);
    step(1'b1, 1'b0, 1'b0);
    chk_all("restart2", 240, 0, 0, 0, 0);

    // Climb to Y=5: 25 flap-ticks to Y=32, then 6 plain ticks.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("climb start", 232, -8, 1, 0, 1);
    m_y = 232;
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, 1'b1, 1'b0);
      m_y = m_y - 8;
      chk_all($sformatf("climb%0d", k), m_y, -8, 1, 0, 1 + k);
    end
    m_v = -8;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b0);
      m_v = m_v + 1;
      m_y = m_y + m_v;
      chk_all($sformatf("coast%0d", k), m_y, m_v, 1, 0, 26);
    end
    chk("at5 BIRD_Y", int'(BIRD_Y), 5);

    // Two flaps between ticks merge; the tick clamps at the ceiling.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_all("ceil pend", 5, -2, 1, 0, 26);
    step(1'b0, 1'b1, 1'b0);
    chk_all("ceil clamp", 0, 0, 1, 0, 27);
    step(1'b1, 1'b1, 1'b0);
    chk_all("ceil coinc", 0, 0, 1, 0, 28);

    // Flap counter saturates at 255.
    for (int i = 1; i <= 230; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_all($sformatf("sat%0d", i), 0, 0, 1, 0,
              (28 + i > 255) ? 255 : 28 + i);
    end
    step(1'b0, 1'b1, 1'b0);
    chk_all("post sat", 1, 1, 1, 0, 255);

    // Asynchronous reset mid-play with a flap pending.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_all("pre reset", 3, 2, 1, 0, 255);
    #2;
    RESET = 1'b1;
    #1;
    chk_all("async reset", 240, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk_all("pend lost", 240, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_all("after reset", 232, -8, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
